// File: rtl/memory_game_pkg.sv
// Shared constants, state type and grid helpers for the 4x4 memory-card game.
package memory_game_pkg;

  localparam int GRID_DIM = 4;
  localparam int N_CARDS  = GRID_DIM * GRID_DIM;
  localparam int N_PAIRS  = N_CARDS / 2;
  localparam int VALUE_W  = 4;
  localparam int COORD_W  = $clog2(GRID_DIM);
  localparam int IDX_W    = $clog2(N_CARDS);

  typedef enum logic [2:0] {
    IDLE,
    ONE_UP,
    COMPARE,
    HOLD,
    DONE
  } game_state_t;

  // Column-major flat index: x selects the group of GRID_DIM, y the offset.
  function automatic logic [IDX_W-1:0] coord_to_idx(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/mismatch_hold_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module mismatch_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/memory_match_fsm.sv
// Pairs consecutive card picks, latches matches, flips mismatches back after a hold,
// and tracks score, turns and game completion.
module memory_match_fsm
  import memory_game_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_valid,
  input  logic [COORD_W-1:0]   sel_x,
  input  logic [COORD_W-1:0]   sel_y,
  input  logic [VALUE_W-1:0]   sel_value,
  output logic [N_CARDS-1:0]   revealed,
  output logic [N_CARDS-1:0]   matched,
  output logic [3:0]           score,
  output logic [7:0]           turns,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic                 busy,
  output logic                 game_over
);

  game_state_t          state_q, state_d;
  logic [N_CARDS-1:0]   revealed_q, revealed_d;
  logic [N_CARDS-1:0]   matched_q, matched_d;
  logic [3:0]           score_q, score_d;
  logic [7:0]           turns_q, turns_d;
  logic                 mp_q, mp_d;
  logic                 mm_q, mm_d;
  logic [IDX_W-1:0]     idx0_q, idx0_d, idx1_q, idx1_d;
  logic [VALUE_W-1:0]   val0_q, val0_d, val1_q, val1_d;

  logic [IDX_W-1:0]     sel_idx;
  logic                 accept;
  logic                 timer_load;
  logic                 hold_done;

  // Face-up cards (including matched ones) can never be picked again.
  assign sel_idx    = coord_to_idx(sel_x, sel_y);
  assign accept     = sel_valid && !revealed_q[sel_idx];
  assign timer_load = (state_q == COMPARE) && (val0_q != val1_q);

  mismatch_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .load(timer_load),
    .done(hold_done)
  );

  always_comb begin
    state_d    = state_q;
    revealed_d = revealed_q;
    matched_d  = matched_q;
    score_d    = score_q;
    turns_d    = turns_q;
    idx0_d     = idx0_q;
    idx1_d     = idx1_q;
    val0_d     = val0_q;
    val1_d     = val1_q;
    mp_d       = 1'b0;
    mm_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx0_d              = sel_idx;
          val0_d              = sel_value;
          revealed_d[sel_idx] = 1'b1;
          state_d             = ONE_UP;
        end
      end
      ONE_UP: begin
        if (accept) begin
          idx1_d              = sel_idx;
          val1_d              = sel_value;
          revealed_d[sel_idx] = 1'b1;
          if (turns_q != 8'hFF) begin
            turns_d = turns_q + 8'd1;
          end
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (val0_q == val1_q) begin
          matched_d[idx0_q] = 1'b1;
          matched_d[idx1_q] = 1'b1;
          score_d           = score_q + 4'd1;
          mp_d              = 1'b1;
          state_d           = (score_d == 4'(N_PAIRS)) ? DONE : IDLE;
        end else begin
          mm_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_done) begin
          revealed_d[idx0_q] = 1'b0;
          revealed_d[idx1_q] = 1'b0;
          state_d            = IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      revealed_q <= '0;
      matched_q  <= '0;
      score_q    <= '0;
      turns_q    <= '0;
      mp_q       <= 1'b0;
      mm_q       <= 1'b0;
      idx0_q     <= '0;
      idx1_q     <= '0;
      val0_q     <= '0;
      val1_q     <= '0;
    end else begin
      state_q    <= state_d;
      revealed_q <= revealed_d;
      matched_q  <= matched_d;
      score_q    <= score_d;
      turns_q    <= turns_d;
      mp_q       <= mp_d;
      mm_q       <= mm_d;
      idx0_q     <= idx0_d;
      idx1_q     <= idx1_d;
      val0_q     <= val0_d;
      val1_q     <= val1_d;
    end
  end

  assign revealed       = revealed_q;
  assign matched        = matched_q;
  assign score          = score_q;
  assign turns          = turns_q;
  assign match_pulse    = mp_q;
  assign mismatch_pulse = mm_q;
  assign busy           = (state_q == COMPARE) || (state_q == HOLD);
  assign game_over      = (state_q == DONE);

endmodule
